jacob_pt_unit: RTL and testbench

//  Parametrised Jacobian-coordinate EC point unit over GF(p); successor to jacob_add.
//  - Curve: y^2 = x^3 + a*x + b. Modes: point add, or point double.
//  - Handles special cases in hardware: infinity in, P==Q, P==-Q.
//  - Datapath: one bit-serial modular multiplier + one 1-cycle mod add/sub, sequenced by microcode FSM.
//  - Sits under the scalar-multiply controller.

---
 rtl/jacob_pt_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_jacob_pt_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jacob_pt_unit.sv
// rtl/jacob_pt_unit.sv - Jacobian EC point add/double over GF(p), microcoded serial datapath
// Optional JACOB_RANGE_CHECK_EN: operand range checks in CHK, reported on err.
module jacob_pt_unit #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] z1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    input  logic [WIDTH-1:0] z2,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] z3,
    output logic             busy,
    output logic             done,
    output logic             inf,
    output logic             err
);
    localparam logic [2:0] S_IDLE = 3'd0, S_CHK = 3'd1, S_COPY = 3'd2, S_EXEC = 3'd3,
                           S_MUL  = 3'd4, S_WB  = 3'd5, S_ACHK = 3'd6, S_FIN  = 3'd7;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2;
    localparam logic [5:0] ADD1_START = 6'd0, ADD1_END = 6'd9, ADD2_START = 6'd10,
                           ADD2_END = 6'd22, DBL_START = 6'd23, DBL_END = 6'd45;
    localparam int CW = $clog2(WIDTH + 1);

    // Register map: 0..5 = X1 Y1 Z1 X2 Y2 Z2, 6 = a, 7/9/13 = X3/Y3/Z3, rest scratch.
    function automatic logic [13:0] ucode(input logic [5:0] pc_i);
        case (pc_i)
            6'd0:  ucode = {OP_MUL, 4'd7,  4'd5,  4'd5};
            6'd1:  ucode = {OP_MUL, 4'd8,  4'd2,  4'd2};
            6'd2:  ucode = {OP_MUL, 4'd9,  4'd0,  4'd7};
            6'd3:  ucode = {OP_MUL, 4'd10, 4'd3,  4'd8};
            6'd4:  ucode = {OP_MUL, 4'd7,  4'd7,  4'd5};
            6'd5:  ucode = {OP_MUL, 4'd8,  4'd8,  4'd2};
            6'd6:  ucode = {OP_MUL, 4'd11, 4'd1,  4'd7};
            6'd7:  ucode = {OP_MUL, 4'd12, 4'd4,  4'd8};
            6'd8:  ucode = {OP_SUB, 4'd10, 4'd10, 4'd9};
            6'd9:  ucode = {OP_SUB, 4'd12, 4'd12, 4'd11};
            6'd10: ucode = {OP_MUL, 4'd7,  4'd10, 4'd10};
            6'd11: ucode = {OP_MUL, 4'd8,  4'd7,  4'd10};
            6'd12: ucode = {OP_MUL, 4'd9,  4'd9,  4'd7};
            6'd13: ucode = {OP_MUL, 4'd7,  4'd12, 4'd12};
            6'd14: ucode = {OP_SUB, 4'd7,  4'd7,  4'd8};
            6'd15: ucode = {OP_SUB, 4'd7,  4'd7,  4'd9};
            6'd16: ucode = {OP_SUB, 4'd7,  4'd7,  4'd9};
            6'd17: ucode = {OP_SUB, 4'd9,  4'd9,  4'd7};
            6'd18: ucode = {OP_MUL, 4'd9,  4'd12, 4'd9};
            6'd19: ucode = {OP_MUL, 4'd8,  4'd11, 4'd8};
            6'd20: ucode = {OP_SUB, 4'd9,  4'd9,  4'd8};
            6'd21: ucode = {OP_MUL, 4'd13, 4'd2,  4'd5};
            6'd22: ucode = {OP_MUL, 4'd13, 4'd13, 4'd10};
            6'd23: ucode = {OP_MUL, 4'd10, 4'd1,  4'd1};
            6'd24: ucode = {OP_MUL, 4'd8,  4'd0,  4'd10};
            6'd25: ucode = {OP_ADD, 4'd8,  4'd8,  4'd8};
            6'd26: ucode = {OP_ADD, 4'd8,  4'd8,  4'd8};
            6'd27: ucode = {OP_MUL, 4'd10, 4'd10, 4'd10};
            6'd28: ucode = {OP_MUL, 4'd12, 4'd2,  4'd2};
            6'd29: ucode = {OP_MUL, 4'd12, 4'd12, 4'd12};
            6'd30: ucode = {OP_MUL, 4'd12, 4'd6,  4'd12};
            6'd31: ucode = {OP_MUL, 4'd14, 4'd0,  4'd0};
            6'd32: ucode = {OP_ADD, 4'd11, 4'd14, 4'd14};
            6'd33: ucode = {OP_ADD, 4'd11, 4'd11, 4'd14};
            6'd34: ucode = {OP_ADD, 4'd11, 4'd11, 4'd12};
            6'd35: ucode = {OP_MUL, 4'd7,  4'd11, 4'd11};
            6'd36: ucode = {OP_SUB, 4'd7,  4'd7,  4'd8};
            6'd37: ucode = {OP_SUB, 4'd7,  4'd7,  4'd8};
            6'd38: ucode = {OP_SUB, 4'd9,  4'd8,  4'd7};
            6'd39: ucode = {OP_MUL, 4'd9,  4'd11, 4'd9};
            6'd40: ucode = {OP_ADD, 4'd10, 4'd10, 4'd10};
            6'd41: ucode = {OP_ADD, 4'd10, 4'd10, 4'd10};
            6'd42: ucode = {OP_ADD, 4'd10, 4'd10, 4'd10};
            6'd43: ucode = {OP_SUB, 4'd9,  4'd9,  4'd10};
            6'd44: ucode = {OP_MUL, 4'd13, 4'd1,  4'd2};
            6'd45: ucode = {OP_ADD, 4'd13, 4'd13, 4'd13};
            default: ucode = 14'd0;
        endcase
    endfunction

    logic [2:0]       state;
    logic [5:0]       pc;
    logic [WIDTH-1:0] rf [0:15];
    logic [WIDTH-1:0] p_r, mul_a, mul_b, res_x, res_y, res_z;
    logic [WIDTH+1:0] mul_acc;
    logic [CW-1:0]    mul_cnt;
    logic             mode_r, use_rf, copy_p2, res_inf, res_err;

    logic [13:0]      uinstr;
    logic [1:0]       op;
    logic [3:0]       dst;
    logic [WIDTH-1:0] opa, opb, addend, wr_data;
    logic [WIDTH:0]   sum, diff, add_res, sub_res;
    logic [WIDTH+1:0] pw, m0, m1, m2;
    logic             step_done, range_bad;

    always_comb begin
        uinstr  = ucode(pc);
        op      = uinstr[13:12];
        dst     = uinstr[11:8];
        opa     = rf[uinstr[7:4]];
        opb     = rf[uinstr[3:0]];
        sum     = {1'b0, opa} + {1'b0, opb};
        add_res = (sum >= {1'b0, p_r}) ? sum - {1'b0, p_r} : sum;
        diff    = {1'b0, opa} - {1'b0, opb};
        sub_res = diff[WIDTH] ? diff + {1'b0, p_r} : diff;
        // One interleaved step: 2*acc + bit*a stays below 3p, so two trial subtracts suffice.
        pw      = {2'b00, p_r};
        addend  = mul_b[WIDTH-1] ? mul_a : {WIDTH{1'b0}};
        m0      = (mul_acc << 1) + {2'b00, addend};
        m1      = (m0 >= pw) ? m0 - pw : m0;
        m2      = (m1 >= pw) ? m1 - pw : m1;
        step_done = ((state == S_EXEC) && (op != OP_MUL)) || (state == S_WB);
        wr_data = (state == S_WB) ? mul_acc[WIDTH-1:0]
                : (op == OP_SUB) ? sub_res[WIDTH-1:0] : add_res[WIDTH-1:0];
`ifdef JACOB_RANGE_CHECK_EN
        range_bad = !p_r[0] || (p_r < WIDTH'(3)) || (rf[6] >= p_r)
                 || (rf[0] >= p_r) || (rf[1] >= p_r) || (rf[2] >= p_r)
                 || (!mode_r && ((rf[3] >= p_r) || (rf[4] >= p_r) || (rf[5] >= p_r)));
`else
        range_bad = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            pc      <= '0;
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            p_r     <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            mul_cnt <= '0;
            res_x   <= '0;
            res_y   <= '0;
            res_z   <= '0;
            mode_r  <= 1'b0;
            use_rf  <= 1'b0;
            copy_p2 <= 1'b0;
            res_inf <= 1'b0;
            res_err <= 1'b0;
            x3      <= '0;
            y3      <= '0;
            z3      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            inf     <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    rf[0] <= x1; rf[1] <= y1; rf[2] <= z1;
                    rf[3] <= x2; rf[4] <= y2; rf[5] <= z2;
                    rf[6] <= a;
                    p_r     <= p;
                    mode_r  <= mode;
                    use_rf  <= 1'b0;
                    res_inf <= 1'b0;
                    res_err <= 1'b0;
                    busy    <= 1'b1;
                    state   <= S_CHK;
                end
                S_CHK: begin
                    if (range_bad) begin
                        {res_x, res_y, res_z} <= '0;
                        res_err <= 1'b1;
                        state   <= S_FIN;
                    end else if (!mode_r) begin
                        if (rf[2] == '0) begin
                            copy_p2 <= 1'b1;
                            state   <= S_COPY;
                        end else if (rf[5] == '0) begin
                            copy_p2 <= 1'b0;
                            state   <= S_COPY;
                        end else begin
                            pc    <= ADD1_START;
                            state <= S_EXEC;
                        end
                    end else if ((rf[2] == '0) || (rf[1] == '0)) begin
                        res_x   <= WIDTH'(1);
                        res_y   <= WIDTH'(1);
                        res_z   <= '0;
                        res_inf <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        pc    <= DBL_START;
                        state <= S_EXEC;
                    end
                end
                S_COPY: begin
                    res_x   <= copy_p2 ? rf[3] : rf[0];
                    res_y   <= copy_p2 ? rf[4] : rf[1];
                    res_z   <= copy_p2 ? rf[5] : rf[2];
                    res_inf <= copy_p2 ? (rf[5] == '0) : (rf[2] == '0);
                    state   <= S_FIN;
                end
                S_EXEC: if (op == OP_MUL) begin
                    mul_a   <= opa;
                    mul_b   <= opb;
                    mul_acc <= '0;
                    mul_cnt <= CW'(WIDTH - 1);
                    state   <= S_MUL;
                end
                S_MUL: begin
                    mul_acc <= m2;
                    mul_b   <= mul_b << 1;
                    if (mul_cnt == '0) state <= S_WB;
                    else mul_cnt <= mul_cnt - CW'(1);
                end
                S_ACHK: begin
                    // H in r10, R in r12: P1==P2 falls back to doubling, P1==-P2 is infinity.
                    if ((rf[10] == '0) && (rf[12] == '0)) begin
                        pc    <= DBL_START;
                        state <= S_EXEC;
                    end else if (rf[10] == '0) begin
                        res_x   <= WIDTH'(1);
                        res_y   <= WIDTH'(1);
                        res_z   <= '0;
                        res_inf <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        pc    <= ADD2_START;
                        state <= S_EXEC;
                    end
                end
                S_FIN: begin
                    x3    <= use_rf ? rf[7]  : res_x;
                    y3    <= use_rf ? rf[9]  : res_y;
                    z3    <= use_rf ? rf[13] : res_z;
                    inf   <= use_rf ? (rf[13] == '0) : res_inf;
                    err   <= res_err;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (step_done) begin
                rf[dst] <= wr_data;
                if (pc == ADD1_END) begin
                    state <= S_ACHK;
                end else if ((pc == ADD2_END) || (pc == DBL_END)) begin
                    use_rf <= 1'b1;
                    state  <= S_FIN;
                end else begin
                    pc    <= pc + 6'd1;
                    state <= S_EXEC;
                end
            end
        end
    end
endmodule

// File: tb/tb_jacob_pt_unit.sv
// tb/tb_jacob_pt_unit.sv - directed bench for jacob_pt_unit on p=29, a=4, WIDTH=8
module tb_jacob_pt_unit;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, mode;
    logic [W-1:0] p, a, x1, y1, z1, x2, y2, z2;
    logic [W-1:0] x3, y3, z3;
    logic         busy, done, inf, err;
    int           passed = 0;
    int           total = 0;
    int           cyc;
    int           ndone;

    jacob_pt_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .p(p), .a(a),
        .x1(x1), .y1(y1), .z1(z1), .x2(x2), .y2(y2), .z2(z2),
        .x3(x3), .y3(y3), .z3(z3), .busy(busy), .done(done), .inf(inf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic m, input logic [W-1:0] ax1, ay1, az1, ax2, ay2, az2);
        mode = m;
        x1 = ax1; y1 = ay1; z1 = az1;
        x2 = ax2; y2 = ay2; z2 = az2;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int c);
        c = 1;
        while (done !== 1'b1 && c < 1000) begin
            tick();
            c++;
        end
        check({tag, "_done"}, done, 1);
    endtask

    task automatic check_pt(input string tag, input logic [W-1:0] ex, ey, ez, input logic einf);
        check({tag, "_x3"}, x3, ex);
        check({tag, "_y3"}, y3, ey);
        check({tag, "_z3"}, z3, ez);
        check({tag, "_inf"}, inf, einf);
        check({tag, "_err"}, err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        p = 8'd29; a = 8'd4;
        x1 = '0; y1 = '0; z1 = '0; x2 = '0; y2 = '0; z2 = '0;
        repeat (3) tick();
        check("rst_xyz", {x3, y3, z3}, 0);
        check("rst_flags", {busy, done, inf, err}, 0);
        rst = 1'b0;
        tick();

        // add (2,6,1)+(3,28,1)
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        check("c1_busy", busy, 1);
        wait_done("c1", cyc);
        check_pt("c1", 8'd15, 8'd27, 8'd1, 1'b0);
        check("c1_lat", cyc <= 30 * (W + 4), 1);
        tick();
        check("c1_pulse", done, 0);

        // double (2,6,1), then a start in the done cycle chains another add
        launch(1'b1, 8'd2, 8'd6, 8'd1, 8'd0, 8'd0, 8'd0);
        wait_done("c2", cyc);
        check_pt("c2", 8'd28, 8'd27, 8'd12, 1'b0);
        check("c2_lat", cyc <= 12 * (W + 4), 1);
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        check("chain_pulse", done, 0);
        check("chain_busy", busy, 1);
        wait_done("chain", cyc);
        check_pt("chain", 8'd15, 8'd27, 8'd1, 1'b0);

        // P==Q falls back to doubling
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd2, 8'd6, 8'd1);
        wait_done("c3", cyc);
        check_pt("c3", 8'd28, 8'd27, 8'd12, 1'b0);
        check("c3_lat", cyc <= 30 * (W + 4), 1);

        // P==-Q gives infinity
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd2, 8'd23, 8'd1);
        wait_done("c4a", cyc);
        check_pt("c4a", 8'd1, 8'd1, 8'd0, 1'b1);

        // z1==0 copies P2
        launch(1'b0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd28, 8'd1);
        wait_done("c4b", cyc);
        check_pt("c4b", 8'd3, 8'd28, 8'd1, 1'b0);
        check("c4b_lat", cyc <= 4, 1);

        // z2==0 copies P1
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd0);
        wait_done("c4c", cyc);
        check_pt("c4c", 8'd2, 8'd6, 8'd1, 1'b0);
        check("c4c_lat", cyc <= 4, 1);

        // doubling a point with y1==0 gives infinity
        launch(1'b1, 8'd5, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0);
        wait_done("c4d", cyc);
        check_pt("c4d", 8'd1, 8'd1, 8'd0, 1'b1);
        check("c4d_lat", cyc <= 4, 1);

        // start while busy is ignored and inputs are captured at start
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        repeat (5) tick();
        launch(1'b1, 8'd7, 8'd9, 8'd3, 8'd4, 8'd5, 8'd6);
        wait_done("c5i", cyc);
        check_pt("c5i", 8'd15, 8'd27, 8'd1, 1'b0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        check("c5i_noqueue", ndone, 0);

        // asynchronous reset mid ADD_SEQ
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        repeat (40) tick();
        check("c5r_busy_pre", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("c5r_xyz", {x3, y3, z3}, 0);
        check("c5r_flags", {busy, done, inf, err}, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("c5r_idle", {busy, done}, 0);
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        wait_done("c5r", cyc);
        check_pt("c5r", 8'd15, 8'd27, 8'd1, 1'b0);

`ifdef JACOB_RANGE_CHECK_EN
        launch(1'b0, 8'd29, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        wait_done("c6x", cyc);
        check("c6x_err", err, 1);
        check("c6x_xyz", {x3, y3, z3, 7'd0, inf}, 0);
        p = 8'd28;
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        wait_done("c6p", cyc);
        check("c6p_err", err, 1);
        check("c6p_xyz", {x3, y3, z3}, 0);
        p = 8'd29;
`else
        launch(1'b0, 8'd2, 8'd6, 8'd1, 8'd3, 8'd28, 8'd1);
        wait_done("c6", cyc);
        check_pt("c6", 8'd15, 8'd27, 8'd1, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
